// File: rtl/mux_scan_nx1.sv
// N-input, W-bit multiplexer with a registered output, plus a round-robin scan mode.
// Scan mode holds each enabled channel for DWELL cycles and then moves to the next one.
module mux_scan_nx1 #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int SW    = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   x,
    input  logic [SW-1:0]    sel,
    input  logic             mode,
    input  logic             load,
    input  logic [N-1:0]     mask,
    output logic [SW-1:0]    ch,
    output logic [W-1:0]     y,
    output logic             valid,
    output logic             wrap
);

    localparam int             CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
    localparam logic [SW:0]    N_EXT    = (SW + 1)'(N);

    logic [SW-1:0]  r_ch;
    logic [W-1:0]   r_y;
    logic           r_valid;
    logic           r_wrap;
    logic [CW-1:0]  r_cnt;

    logic [W-1:0]   w_chan [N];
    logic [2*N-1:0] w_dbl;
    logic [SW:0]    w_shamt;
    logic [2*N-1:0] w_rot;
    logic           w_found;
    logic [SW-1:0]  w_off;
    logic [SW:0]    w_sum;
    logic           w_wraps;
    logic [SW-1:0]  w_adv_ch;
    logic           w_sel_ok;
    logic [SW-1:0]  w_sel_ch;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign w_chan[gi] = x[gi*W +: W];
        end
    endgenerate

    // Rotate the mask so bit i is the enable of channel ch+1+i (mod N).
    assign w_dbl   = {mask, mask};
    assign w_shamt = {1'b0, r_ch} + (SW + 1)'(1);
    assign w_rot   = w_dbl >> w_shamt;

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = N - 2; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = SW'(i);
            end
        end
    end

    // The search crossed channel N-1 exactly when the raw sum reaches N.
    assign w_sum    = {1'b0, r_ch} + (SW + 1)'(1) + {1'b0, w_off};
    assign w_wraps  = (w_sum >= N_EXT);
    assign w_adv_ch = w_wraps ? SW'(w_sum - N_EXT) : w_sum[SW-1:0];

    assign w_sel_ok = ({1'b0, sel} < N_EXT);
    assign w_sel_ch = w_sel_ok ? sel : r_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch    <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_y     <= w_chan[r_ch];
            r_valid <= mask[r_ch];
            if (!mode || load) begin
                r_ch   <= w_sel_ch;
                r_cnt  <= '0;
                r_wrap <= 1'b0;
            end else if (r_cnt != CNT_LAST) begin
                r_cnt  <= r_cnt + CW'(1);
                r_wrap <= 1'b0;
            end else begin
                r_cnt <= '0;
                if (w_found) begin
                    r_ch   <= w_adv_ch;
                    r_wrap <= w_wraps;
                end else begin
                    r_wrap <= 1'b0;
                end
            end
        end
    end

    assign ch    = r_ch;
    assign y     = r_y;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule
